// File: rtl/mc_fifo_s1_sf_if.sv
// Request/response bundle of the multi-channel FIFO: master is the requester,
// slave is the FIFO. Flag vectors carry one bit per channel, bit i = channel i.
interface mc_fifo_s1_sf_if #(
  parameter int width  = 8,
  parameter int num_ch = 4,
  parameter int chb    = (num_ch > 1) ? $clog2(num_ch) : 1
);
  logic              push_req_n;
  logic [chb-1:0]    push_ch;
  logic [width-1:0]  data_in;
  logic              pop_req_n;
  logic [chb-1:0]    pop_ch;
  logic [width-1:0]  data_out;
  logic [num_ch-1:0] empty;
  logic [num_ch-1:0] almost_empty;
  logic [num_ch-1:0] half_full;
  logic [num_ch-1:0] almost_full;
  logic [num_ch-1:0] full;
  logic [num_ch-1:0] error;

  modport master (
    output push_req_n, push_ch, data_in, pop_req_n, pop_ch,
    input  data_out, empty, almost_empty, half_full, almost_full, full, error
  );

  modport slave (
    input  push_req_n, push_ch, data_in, pop_req_n, pop_ch,
    output data_out, empty, almost_empty, half_full, almost_full, full, error
  );
endinterface

// File: rtl/mc_fifo_s1_sf.sv
// Single-clock FIFO holding num_ch independent channels of depth words each.
// Optional macro MC_FIFO_S1_SF_WORD_COUNT_EN adds the word_count output.
module mc_fifo_s1_sf #(
  parameter int width    = 8,
  parameter int depth    = 8,
  parameter int num_ch   = 4,
  parameter int ae_level = 2,
  parameter int af_level = 2,
  parameter int err_mode = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  mc_fifo_s1_sf_if.slave     fifo_if
`ifdef MC_FIFO_S1_SF_WORD_COUNT_EN
  ,
  output logic [num_ch*$clog2(depth+1)-1:0] word_count
`endif
);

  localparam int chb = (num_ch > 1) ? $clog2(num_ch) : 1;
  localparam int pw  = $clog2(depth);
  localparam int cw  = $clog2(depth + 1);

  localparam logic [pw-1:0] PTR_LAST = pw'(depth - 1);
  localparam logic [cw-1:0] CNT_FULL = cw'(depth);
  localparam logic [cw-1:0] AE_LVL   = cw'(ae_level);
  localparam logic [cw-1:0] HF_LVL   = cw'((depth + 1) / 2);
  localparam logic [cw-1:0] AF_LVL   = cw'(depth - af_level);

  // Handshake: push_req_n/pop_req_n are sampled every rising edge; a low
  // request is one attempt that is accepted or rejected in that same cycle
  // from the current count, with rejection reported on error the cycle after.

  logic [width-1:0]  mem [num_ch][depth];

  logic [pw-1:0]     wr_q [num_ch];
  logic [pw-1:0]     wr_d [num_ch];
  logic [pw-1:0]     rd_q [num_ch];
  logic [pw-1:0]     rd_d [num_ch];
  logic [cw-1:0]     cnt_q [num_ch];
  logic [cw-1:0]     cnt_d [num_ch];

  logic [num_ch-1:0] empty_q, empty_d;
  logic [num_ch-1:0] ae_q, ae_d;
  logic [num_ch-1:0] hf_q, hf_d;
  logic [num_ch-1:0] af_q, af_d;
  logic [num_ch-1:0] full_q, full_d;
  logic [num_ch-1:0] err_q, err_d;

  logic [num_ch-1:0] push_hit, pop_hit, push_ok, pop_ok, rej;
  logic [width-1:0]  rd_data;

  always_comb begin
    for (int i = 0; i < num_ch; i++) begin
      push_hit[i] = !fifo_if.push_req_n && (fifo_if.push_ch == chb'(i));
      pop_hit[i]  = !fifo_if.pop_req_n  && (fifo_if.pop_ch  == chb'(i));
      // A full channel still takes a push when the same cycle pops it.
      push_ok[i]  = push_hit[i] && (!full_q[i] || pop_hit[i]);
      pop_ok[i]   = pop_hit[i] && !empty_q[i];
      rej[i]      = (push_hit[i] && !push_ok[i]) || (pop_hit[i] && !pop_ok[i]);

      wr_d[i] = wr_q[i];
      if (push_ok[i]) wr_d[i] = (wr_q[i] == PTR_LAST) ? '0 : wr_q[i] + pw'(1);
      rd_d[i] = rd_q[i];
      if (pop_ok[i]) rd_d[i] = (rd_q[i] == PTR_LAST) ? '0 : rd_q[i] + pw'(1);
      cnt_d[i] = cnt_q[i] + cw'(push_ok[i]) - cw'(pop_ok[i]);

      empty_d[i] = (cnt_d[i] == '0);
      ae_d[i]    = (cnt_d[i] <= AE_LVL);
      hf_d[i]    = (cnt_d[i] >= HF_LVL);
      af_d[i]    = (cnt_d[i] >= AF_LVL);
      full_d[i]  = (cnt_d[i] == CNT_FULL);
      err_d[i]   = (err_mode == 0) ? (err_q[i] || rej[i]) : rej[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < num_ch; i++) begin
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      empty_q <= '1;
      ae_q    <= '1;
      hf_q    <= '0;
      af_q    <= '0;
      full_q  <= '0;
      err_q   <= '0;
    end else begin
      for (int i = 0; i < num_ch; i++) begin
        wr_q[i]  <= wr_d[i];
        rd_q[i]  <= rd_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      empty_q <= empty_d;
      ae_q    <= ae_d;
      hf_q    <= hf_d;
      af_q    <= af_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately left out of reset; the empty gate on the read
  // path keeps stale words from ever reaching data_out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < num_ch; i++) begin
      if (push_ok[i]) mem[i][wr_q[i]] <= fifo_if.data_in;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < num_ch; i++) begin
      if ((fifo_if.pop_ch == chb'(i)) && !empty_q[i]) rd_data = mem[i][rd_q[i]];
    end
  end

  assign fifo_if.data_out     = rd_data;
  assign fifo_if.empty        = empty_q;
  assign fifo_if.almost_empty = ae_q;
  assign fifo_if.half_full    = hf_q;
  assign fifo_if.almost_full  = af_q;
  assign fifo_if.full         = full_q;
  assign fifo_if.error        = err_q;

`ifdef MC_FIFO_S1_SF_WORD_COUNT_EN
  always_comb begin
    word_count = '0;
    for (int i = 0; i < num_ch; i++) word_count[i*cw +: cw] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_mc_fifo_s1_sf.sv
// Bench for mc_fifo_s1_sf: a depth-8/4-channel sticky-error instance driven by a
// vector table, and a depth-5/3-channel single-cycle-error instance for corners.
module tb_mc_fifo_s1_sf;

  logic clk;
  logic rst_n;

  mc_fifo_s1_sf_if #(.width(8), .num_ch(4)) bus_a ();
  mc_fifo_s1_sf_if #(.width(8), .num_ch(3)) bus_b ();

`ifdef MC_FIFO_S1_SF_WORD_COUNT_EN
  logic [15:0] wc_a;
  logic [8:0]  wc_b;
`endif

  mc_fifo_s1_sf #(.width(8), .depth(8), .num_ch(4), .ae_level(2), .af_level(2), .err_mode(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .fifo_if(bus_a)
`ifdef MC_FIFO_S1_SF_WORD_COUNT_EN
    , .word_count(wc_a)
`endif
  );

  mc_fifo_s1_sf #(.width(8), .depth(5), .num_ch(3), .ae_level(1), .af_level(1), .err_mode(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_if(bus_b)
`ifdef MC_FIFO_S1_SF_WORD_COUNT_EN
    , .word_count(wc_b)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       pn;
    logic [1:0] pc;
    logic [7:0] d;
    logic       qn;
    logic [1:0] qc;
    logic [7:0] e_dout;
    logic [3:0] e_empty;
    logic [3:0] e_ae;
    logic [3:0] e_hf;
    logic [3:0] e_af;
    logic [3:0] e_full;
    logic [3:0] e_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic pn, input logic [1:0] pc, input logic [7:0] d,
                     input logic qn, input logic [1:0] qc, input logic [7:0] e_dout,
                     input logic [3:0] e_empty, input logic [3:0] e_ae, input logic [3:0] e_hf,
                     input logic [3:0] e_af, input logic [3:0] e_full, input logic [3:0] e_err);
    vec_t v;
    v.pn = pn; v.pc = pc; v.d = d; v.qn = qn; v.qc = qc; v.e_dout = e_dout;
    v.e_empty = e_empty; v.e_ae = e_ae; v.e_hf = e_hf; v.e_af = e_af;
    v.e_full = e_full; v.e_err = e_err;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive_a(input logic pn, input logic [1:0] pc, input logic [7:0] d,
                         input logic qn, input logic [1:0] qc);
    bus_a.push_req_n = pn; bus_a.push_ch = pc; bus_a.data_in = d;
    bus_a.pop_req_n  = qn; bus_a.pop_ch  = qc;
  endtask

  task automatic drive_b(input logic pn, input logic [1:0] pc, input logic [7:0] d,
                         input logic qn, input logic [1:0] qc);
    bus_b.push_req_n = pn; bus_b.push_ch = pc; bus_b.data_in = d;
    bus_b.pop_req_n  = qn; bus_b.pop_ch  = qc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [3:0] F = 4'b1111;
  localparam logic [3:0] Z = 4'b0000;
  localparam logic [3:0] C2 = 4'b0100;

  initial begin
    logic [7:0] e;
    rst_n = 1'b0;
    drive_a(1'b1, 2'd0, 8'h00, 1'b1, 2'd0);
    drive_b(1'b1, 2'd0, 8'h00, 1'b1, 2'd0);

    // ch1 ordering, ch2 fill/overflow/drain, ch3 pop-empty (sticky error)
    add(0,1,8'h11,1,1, 8'h00, 4'b1101, F,       Z,  Z,  Z,  Z);
    add(0,1,8'h22,1,1, 8'h11, 4'b1101, F,       Z,  Z,  Z,  Z);
    add(0,1,8'h33,1,1, 8'h11, 4'b1101, 4'b1101, Z,  Z,  Z,  Z);
    add(1,0,8'h00,0,1, 8'h11, 4'b1101, F,       Z,  Z,  Z,  Z);
    add(1,0,8'h00,0,1, 8'h22, 4'b1101, F,       Z,  Z,  Z,  Z);
    add(1,0,8'h00,0,1, 8'h33, F,       F,       Z,  Z,  Z,  Z);
    add(1,0,8'h00,1,1, 8'h00, F,       F,       Z,  Z,  Z,  Z);
    add(0,2,8'hA0,1,2, 8'h00, 4'b1011, F,       Z,  Z,  Z,  Z);
    add(0,2,8'hA1,1,2, 8'hA0, 4'b1011, F,       Z,  Z,  Z,  Z);
    add(0,2,8'hA2,1,2, 8'hA0, 4'b1011, 4'b1011, Z,  Z,  Z,  Z);
    add(0,2,8'hA3,1,2, 8'hA0, 4'b1011, 4'b1011, C2, Z,  Z,  Z);
    add(0,2,8'hA4,1,2, 8'hA0, 4'b1011, 4'b1011, C2, Z,  Z,  Z);
    add(0,2,8'hA5,1,2, 8'hA0, 4'b1011, 4'b1011, C2, C2, Z,  Z);
    add(0,2,8'hA6,1,2, 8'hA0, 4'b1011, 4'b1011, C2, C2, Z,  Z);
    add(0,2,8'hA7,1,2, 8'hA0, 4'b1011, 4'b1011, C2, C2, C2, Z);
    add(0,2,8'hEE,1,2, 8'hA0, 4'b1011, 4'b1011, C2, C2, C2, C2);
    add(1,0,8'h00,0,2, 8'hA0, 4'b1011, 4'b1011, C2, C2, Z,  C2);
    add(1,0,8'h00,0,2, 8'hA1, 4'b1011, 4'b1011, C2, C2, Z,  C2);
    add(1,0,8'h00,0,2, 8'hA2, 4'b1011, 4'b1011, C2, Z,  Z,  C2);
    add(1,0,8'h00,0,2, 8'hA3, 4'b1011, 4'b1011, C2, Z,  Z,  C2);
    add(1,0,8'h00,0,2, 8'hA4, 4'b1011, 4'b1011, Z,  Z,  Z,  C2);
    add(1,0,8'h00,0,2, 8'hA5, 4'b1011, F,       Z,  Z,  Z,  C2);
    add(1,0,8'h00,0,2, 8'hA6, 4'b1011, F,       Z,  Z,  Z,  C2);
    add(1,0,8'h00,0,2, 8'hA7, F,       F,       Z,  Z,  Z,  C2);
    add(1,0,8'h00,0,3, 8'h00, F,       F,       Z,  Z,  Z,  4'b1100);
    add(1,0,8'h00,1,3, 8'h00, F,       F,       Z,  Z,  Z,  4'b1100);

    repeat (2) @(posedge clk);
    #1;
    chk("rst.empty",  bus_a.empty,        F);
    chk("rst.ae",     bus_a.almost_empty, F);
    chk("rst.hf",     bus_a.half_full,    Z);
    chk("rst.af",     bus_a.almost_full,  Z);
    chk("rst.full",   bus_a.full,         Z);
    chk("rst.err",    bus_a.error,        Z);
    chk("rst.dout",   bus_a.data_out,     8'h00);
    chk("rst.empty_b", bus_b.empty,       3'b111);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < vq.size(); i++) begin
      drive_a(vq[i].pn, vq[i].pc, vq[i].d, vq[i].qn, vq[i].qc);
      #1;
      chk($sformatf("vec%0d.dout", i), bus_a.data_out, vq[i].e_dout);
      step();
      chk($sformatf("vec%0d.empty", i), bus_a.empty,        vq[i].e_empty);
      chk($sformatf("vec%0d.ae", i),    bus_a.almost_empty, vq[i].e_ae);
      chk($sformatf("vec%0d.hf", i),    bus_a.half_full,    vq[i].e_hf);
      chk($sformatf("vec%0d.af", i),    bus_a.almost_full,  vq[i].e_af);
      chk($sformatf("vec%0d.full", i),  bus_a.full,         vq[i].e_full);
      chk($sformatf("vec%0d.err", i),   bus_a.error,        vq[i].e_err);
    end

    // full ch0 with simultaneous push+pop
    for (int k = 0; k < 8; k++) begin
      drive_a(1'b0, 2'd0, 8'(8'hC0 + k), 1'b1, 2'd0);
      exp_q.push_back(8'(8'hC0 + k));
      step();
    end
    chk("pp.full_before", bus_a.full, 4'b0001);
    drive_a(1'b0, 2'd0, 8'hC8, 1'b0, 2'd0);
    #1;
    e = exp_q.pop_front();
    chk("pp.dout", bus_a.data_out, e);
    exp_q.push_back(8'hC8);
    step();
    chk("pp.full_after", bus_a.full, 4'b0001);
    chk("pp.err",        bus_a.error, 4'b1100);
    for (int k = 0; k < 8; k++) begin
      drive_a(1'b1, 2'd0, 8'h00, 1'b0, 2'd0);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("pp.drain%0d", k), bus_a.data_out, e);
      step();
    end
    chk("pp.empty", bus_a.empty, F);

    // asynchronous reset in the middle of a cycle with ch1 holding data
    for (int k = 0; k < 4; k++) begin
      drive_a(1'b0, 2'd1, 8'(8'hD0 + k), 1'b1, 2'd1);
      step();
    end
    drive_a(1'b1, 2'd0, 8'h00, 1'b1, 2'd1);
    #1;
    chk("ar.dout_pre", bus_a.data_out, 8'hD0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.empty", bus_a.empty,        F);
    chk("ar.ae",    bus_a.almost_empty, F);
    chk("ar.err",   bus_a.error,        Z);
    chk("ar.full",  bus_a.full,         Z);
    chk("ar.dout",  bus_a.data_out,     8'h00);
    step();
    chk("ar.hold_empty", bus_a.empty, F);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("ar.stale_dout", bus_a.data_out, 8'h00);
    chk("ar.err_post",   bus_a.error,    Z);

    // depth 5: wrap with paired push/pop, overflow, single-cycle errors
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      drive_b(1'b0, 2'd0, 8'(8'h50 + k), 1'b1, 2'd0);
      exp_q.push_back(8'(8'h50 + k));
      step();
    end
    chk("d5.af",    bus_b.almost_full,  3'b001);
    chk("d5.hf",    bus_b.half_full,    3'b001);
    chk("d5.ae",    bus_b.almost_empty, 3'b110);
    chk("d5.empty", bus_b.empty,        3'b110);
    for (int k = 0; k < 12; k++) begin
      drive_b(1'b0, 2'd0, 8'(8'h60 + k), 1'b0, 2'd0);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("d5.pair%0d", k), bus_b.data_out, e);
      exp_q.push_back(8'(8'h60 + k));
      step();
`ifdef MC_FIFO_S1_SF_WORD_COUNT_EN
      chk($sformatf("d5.wc%0d", k), wc_b[2:0], 3'd4);
`endif
    end
    chk("d5.pair_full", bus_b.full,  3'b000);
    chk("d5.pair_err",  bus_b.error, 3'b000);
    drive_b(1'b0, 2'd0, 8'h7A, 1'b1, 2'd0);
    exp_q.push_back(8'h7A);
    step();
    chk("d5.full", bus_b.full, 3'b001);
    drive_b(1'b0, 2'd0, 8'h7B, 1'b1, 2'd0);
    step();
    chk("d5.ovf_err",  bus_b.error, 3'b001);
    chk("d5.ovf_full", bus_b.full,  3'b001);
    drive_b(1'b1, 2'd0, 8'h00, 1'b1, 2'd0);
    step();
    chk("d5.err_clr", bus_b.error, 3'b000);
`ifdef MC_FIFO_S1_SF_WORD_COUNT_EN
    chk("d5.wc_full", wc_b[2:0], 3'd5);
`endif
    for (int k = 0; k < 5; k++) begin
      drive_b(1'b1, 2'd0, 8'h00, 1'b0, 2'd0);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("d5.drain%0d", k), bus_b.data_out, e);
      step();
    end
    chk("d5.empty_all", bus_b.empty, 3'b111);
    chk("d5.err_drain", bus_b.error, 3'b000);

    // empty channel: push accepted, pop rejected, word visible next cycle
    drive_b(1'b0, 2'd1, 8'h5C, 1'b0, 2'd1);
    #1;
    chk("pe.dout_pre", bus_b.data_out, 8'h00);
    step();
    drive_b(1'b1, 2'd0, 8'h00, 1'b1, 2'd1);
    chk("pe.err",   bus_b.error, 3'b010);
    chk("pe.empty", bus_b.empty, 3'b101);
    #1;
    chk("pe.dout", bus_b.data_out, 8'h5C);
    step();
    chk("pe.err_clr", bus_b.error, 3'b000);

    // push ch2 and pop ch1 in the same cycle
    drive_b(1'b0, 2'd2, 8'h3D, 1'b0, 2'd1);
    #1;
    chk("xc.dout", bus_b.data_out, 8'h5C);
    step();
    chk("xc.empty", bus_b.empty, 3'b011);
    chk("xc.err",   bus_b.error, 3'b000);

    // pop from empty ch0 with single-cycle error
    drive_b(1'b1, 2'd0, 8'h00, 1'b0, 2'd0);
    #1;
    chk("ue.dout", bus_b.data_out, 8'h00);
    step();
    drive_b(1'b1, 2'd0, 8'h00, 1'b1, 2'd0);
    chk("ue.err", bus_b.error, 3'b001);
    step();
    chk("ue.err_clr", bus_b.error, 3'b000);

    // channel index out of range is ignored
    drive_b(1'b0, 2'd3, 8'hFF, 1'b0, 2'd3);
    #1;
    chk("oor.dout", bus_b.data_out, 8'h00);
    step();
    chk("oor.err",   bus_b.error, 3'b000);
    chk("oor.empty", bus_b.empty, 3'b011);
    drive_b(1'b1, 2'd0, 8'h00, 1'b0, 2'd2);
    #1;
    chk("oor.ch2_dout", bus_b.data_out, 8'h3D);
    step();
    drive_b(1'b1, 2'd0, 8'h00, 1'b1, 2'd0);
    chk("oor.final_empty", bus_b.empty, 3'b111);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mc_fifo_s1_sf.md
MC_FIFO_S1_SF -- requirements
Module: mc_fifo_s1_sf

Interface
REQ-001 SHALL have parameter width, default 8, data word width in bits (1..256).
REQ-002 SHALL have parameter depth, default 8, entries per channel (2..256, any integer).
REQ-003 SHALL have parameter num_ch, default 4, independent channel count (1..8); chb = max(1, ceil(log2(num_ch))).
REQ-004 SHALL have parameter ae_level, default 2, almost-empty threshold (1..depth-1).
REQ-005 SHALL have parameter af_level, default 2, almost-full threshold (1..depth-1).
REQ-006 SHALL have parameter err_mode, default 0: 0 = sticky error, 1 = single-cycle error.
REQ-007 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-009 SHALL have ports push_req_n  input  1  push request, active low; push_ch  input  chb  push channel.
REQ-010 SHALL have port data_in  input  width  write word.
REQ-011 SHALL have ports pop_req_n  input  1  pop request, active low; pop_ch  input  chb  pop channel.
REQ-012 SHALL have port data_out  output  width  head word of channel pop_ch.
REQ-013 SHALL have outputs empty, almost_empty, half_full, almost_full, full, error, each num_ch bits, bit i for channel i.

Function
REQ-014 SHALL keep per-channel write pointer, read pointer and count (0..depth); pointers wrap depth-1 -> 0, including non-power-of-2 depth.
REQ-015 SHALL accept push when push_req_n=0, push_ch<num_ch and channel not full; word written at write pointer, count+1 at next edge.
REQ-016 SHALL accept pop when pop_req_n=0, pop_ch<num_ch and channel not empty; read pointer advances, count-1 at next edge.
REQ-017 SHALL, on same-channel push+pop: if full, accept both (count unchanged); if empty, accept push, reject pop (pop error).
REQ-018 SHALL process push and pop to different channels independently in the same cycle.
REQ-019 SHALL reject push to full channel without push+pop: no write, no pointer change, error bit of that channel raised.
REQ-020 SHALL reject pop from empty channel: no pointer change, error bit of that channel raised.
REQ-021 SHALL ignore requests with channel index >= num_ch: no state change, no error.
REQ-022 SHALL drive data_out combinationally as word at read pointer of pop_ch; 0 when that channel is empty or pop_ch >= num_ch.
REQ-023 SHALL register flags from post-update count: empty = (count==0), almost_empty = (count<=ae_level), half_full = (count>=(depth+1)/2), almost_full = (count>=depth-af_level), full = (count==depth).
REQ-024 SHALL, err_mode=0, hold error bit set until reset; err_mode=1, assert error bit for exactly the cycle after each rejected request.
REQ-025 SHALL give write-to-read latency of one cycle: word pushed at edge N is visible on data_out after edge N if it becomes head.

Reset
REQ-026 SHALL, on rst_n=0 at any time including mid-operation, asynchronously clear all pointers and counts; empty and almost_empty all ones; half_full, almost_full, full, error all zeros; data_out 0.
REQ-027 SHALL not reset storage contents; no stale word is observable after reset (REQ-022).

Configuration
REQ-028 SHALL, with macro MC_FIFO_S1_SF_WORD_COUNT_EN defined, add output word_count  num_ch*(ceil(log2(depth+1)))  registered count of each channel, channel i in slice i, reset 0.
REQ-029 SHALL, without MC_FIFO_S1_SF_WORD_COUNT_EN, omit port word_count and its logic; all other behaviour identical.

Verification
REQ-030 SHALL test: reset, push 0x11,0x22,0x33 to ch1, pop ch1 x3 -> data_out 0x11,0x22,0x33 in order; ch0/2/3 empty=1 throughout.
REQ-031 SHALL test: push 8 words to ch2 (depth 8) -> full[2]=1 after 8th edge, almost_full[2]=1 after 6th; 9th push -> error[2]=1, contents unchanged.
REQ-032 SHALL test: ch0 full, push+pop ch0 same cycle -> both accepted, full[0] stays 1, error[0]=0, order preserved.
REQ-033 SHALL test: ch3 empty, pop ch3 -> error[3]=1 (err_mode=0 remains 1; err_mode=1 clears next cycle), data_out=0.
REQ-034 SHALL test: 4 words in ch1, assert rst_n=0 mid-cycle -> empty=4'b1111, error=0, data_out=0 immediately, before next clk edge.
REQ-035 SHALL test: depth=5, 12 push/pop pairs on ch0 -> pointer wrap, data matches scoreboard; word_count[ch0] matches when macro defined.
